da_fifo: RTL and testbench

// - Dual-clock FIFO on the DAC/output path; the reverse of the ADC capture FIFO.
// - Host/DSP logic writes packed 2*DSIZE words on wclk; the DAC side reads one DSIZE sample per request on rclk.
// - Each word unpacks upper half first, then lower half, matching the ADC-side packing order {older, newer}.
// - Gray-coded pointers with 2-flop synchronizers; registered full/empty flags.

---
 rtl/da_fifo_pkg.sv | 16 +
 rtl/da_fifo_sync2.sv | 26 ++
 rtl/da_fifo.sv | 125 ++++++++++++
 tb/tb_da_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/da_fifo_pkg.sv
// Shared definitions for the DAC output FIFO: gray-code helper and the
// half-word selector used when unpacking {first, second} sample pairs.
package da_fifo_pkg;

  // Which half of the current packed word the next read returns.
  typedef enum logic {
    HALF_UPPER = 1'b0,
    HALF_LOWER = 1'b1
  } half_e;

  // Binary to reflected gray code; callers size the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/da_fifo_sync2.sv
// Two-flop synchronizer for a gray-coded pointer crossing into clk's domain.
module da_fifo_sync2
  import da_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop presents a settled value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/da_fifo.sv
// Dual-clock output FIFO: packed {first, second} sample words go in on wclk,
// single samples come out on rclk, upper half first. Gray pointers cross
// the clock boundary through two-flop synchronizers; flags are registered.
module da_fifo
  import da_fifo_pkg::*;
#(
  parameter int DSIZE = 10,
  parameter int ASIZE = 4
) (
  input  logic               wclk,
  input  logic               rst,
  input  logic               rclk,
  input  logic               wreq,
  input  logic [2*DSIZE-1:0] wdata,
  output logic               full,
  output logic               overflow,
  input  logic               rreq,
  output logic [DSIZE-1:0]   rdata,
  output logic               rvalid,
  output logic               empty,
  output logic               underflow
);

  localparam int MDSIZE = 2 * DSIZE;
  localparam int PW     = ASIZE + 1;
  localparam int DEPTH  = 1 << ASIZE;

  // Word storage; not reset, contents are only meaningful between pointers.
  logic [MDSIZE-1:0] mem [DEPTH];

  // Write-domain state.
  logic [PW-1:0] wptr, wptr_next;
  logic [PW-1:0] wgray, wgray_next;
  logic [PW-1:0] rgray_w;
  logic [PW-1:0] full_match;
  logic          wr_ok;

  // Read-domain state.
  logic [PW-1:0]     rptr, rptr_next;
  logic [PW-1:0]     rgray, rgray_next;
  logic [PW-1:0]     wgray_r;
  logic [MDSIZE-1:0] rword;
  half_e             half;
  logic              rd_ok;

  // Pointer synchronizers: only gray-coded values cross between domains.
  da_fifo_sync2 #(.W(PW)) u_sync_w2r (
    .clk (rclk),
    .rst (rst),
    .d   (wgray),
    .q   (wgray_r)
  );

  da_fifo_sync2 #(.W(PW)) u_sync_r2w (
    .clk (wclk),
    .rst (rst),
    .d   (rgray),
    .q   (rgray_w)
  );

  // Write side: a full FIFO means the write pointer has lapped the read
  // pointer by one depth, which in gray code flips the top two bits.
  assign wr_ok      = wreq && !full;
  assign wptr_next  = wptr + PW'(wr_ok);
  assign wgray_next = PW'(bin2gray(32'(wptr_next)));
  assign full_match = {~rgray_w[ASIZE:ASIZE-1], rgray_w[ASIZE-2:0]};

  // Write pointer, full flag and sticky overflow in the wclk domain.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      wgray    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr_next;
      wgray    <= wgray_next;
      full     <= (wgray_next == full_match);
      overflow <= overflow | (wreq && full);
    end
  end

  // RAM write port; a dropped write never touches memory.
  always_ff @(posedge wclk) begin
    if (wr_ok) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  // Read side: the word slot is released only after its lower half is read,
  // so a half-consumed word keeps the FIFO non-empty.
  assign rword      = mem[rptr[ASIZE-1:0]];
  assign rd_ok      = rreq && !empty;
  assign rptr_next  = rptr + PW'(rd_ok && (half == HALF_LOWER));
  assign rgray_next = PW'(bin2gray(32'(rptr_next)));

  // Read pointer, half selector, output register, empty and sticky underflow.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      rptr      <= '0;
      rgray     <= '0;
      half      <= HALF_UPPER;
      empty     <= 1'b1;
      underflow <= 1'b0;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      rptr      <= rptr_next;
      rgray     <= rgray_next;
      empty     <= (rgray_next == wgray_r);
      underflow <= underflow | (rreq && empty);
      rvalid    <= rd_ok;
      if (rd_ok) begin
        if (half == HALF_UPPER) begin
          rdata <= rword[MDSIZE-1:DSIZE];
          half  <= HALF_LOWER;
        end else begin
          rdata <= rword[DSIZE-1:0];
          half  <= HALF_UPPER;
        end
      end
    end
  end

endmodule

// File: tb/tb_da_fifo.sv
// Directed and randomized-handshake bench for the DAC output FIFO.
module tb_da_fifo;

  localparam int DSIZE = 10;
  localparam int ASIZE = 4;

  logic               wclk = 1'b0;
  logic               rclk = 1'b0;
  logic               rst  = 1'b0;
  logic               wreq = 1'b0;
  logic [2*DSIZE-1:0] wdata = '0;
  logic               rreq = 1'b0;
  logic               full, overflow, rvalid, empty, underflow;
  logic [DSIZE-1:0]   rdata;

  int n_tests = 0;
  int n_fail  = 0;

  da_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .wclk      (wclk),
    .rst       (rst),
    .rclk      (rclk),
    .wreq      (wreq),
    .wdata     (wdata),
    .full      (full),
    .overflow  (overflow),
    .rreq      (rreq),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .empty     (empty),
    .underflow (underflow)
  );

  // wclk period 100, rclk period 270 (100 MHz : 37 MHz); rclk edges offset
  // by 3 so they never coincide with wclk edges.
  always #50 wclk = ~wclk;
  initial begin
    #3;
    forever #135 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2*DSIZE-1:0] d);
    @(negedge wclk);
    wreq  = 1'b1;
    wdata = d;
    @(posedge wclk);
    #1;
    wreq = 1'b0;
  endtask

  task automatic rd(output logic [DSIZE-1:0] d, output logic v);
    @(negedge rclk);
    rreq = 1'b1;
    @(posedge rclk);
    #1;
    rreq = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  task automatic wait_not_empty(input string tag);
    int n;
    n = 0;
    while (empty && n < 10) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk(tag, 32'(empty), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"},     32'(empty),     1);
    chk({tag, "_full"},      32'(full),      0);
    chk({tag, "_rvalid"},    32'(rvalid),    0);
    chk({tag, "_rdata"},     32'(rdata),     0);
    chk({tag, "_overflow"},  32'(overflow),  0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DSIZE-1:0] d;
    logic             v;
    int               n;

    // Reset held, then released with idle cycles.
    #200;
    chk_reset_state("rst_hold");
    @(negedge wclk);
    rst = 1'b1;
    repeat (10) @(posedge wclk);
    #1;
    chk_reset_state("rst_idle");

    // Unpack order and write->empty latency.
    wr(20'hAA955);
    n = 0;
    while (empty && n < 6) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("unpack_empty_fall", 32'(empty), 0);
    chk("unpack_empty_lat", 32'(n <= 3), 1);
    rd(d, v);
    chk("unpack_v0", 32'(v), 1);
    chk("unpack_d0", 32'(d), 32'h2AA);
    rd(d, v);
    chk("unpack_v1", 32'(v), 1);
    chk("unpack_d1", 32'(d), 32'h155);
    chk("unpack_empty_after", 32'(empty), 1);

    // Fill to full, one dropped write, then drain in order.
    for (int i = 0; i < 16; i++) begin
      @(negedge wclk);
      if (i == 15) chk("fill_not_full_yet", 32'(full), 0);
      wreq  = 1'b1;
      wdata = {10'(i), 10'(i + 16)};
    end
    @(negedge wclk);
    wreq = 1'b0;
    chk("fill_full", 32'(full), 1);
    chk("fill_no_overflow", 32'(overflow), 0);
    wreq  = 1'b1;
    wdata = 20'hFFFFF;
    @(negedge wclk);
    wreq = 1'b0;
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    wait_not_empty("drain_ready");
    for (int j = 0; j < 32; j++) begin
      rd(d, v);
      chk("drain_valid", 32'(v), 1);
      chk("drain_data", 32'(d), (j % 2 == 0) ? (j / 2) : (j / 2 + 16));
    end
    chk("drain_empty", 32'(empty), 1);
    repeat (4) @(posedge wclk);
    #1;
    chk("drain_full_clear", 32'(full), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // Underflow: read while empty.
    chk("udf_clear_before", 32'(underflow), 0);
    rd(d, v);
    chk("udf_rvalid", 32'(v), 0);
    chk("udf_rdata_hold", 32'(d), 31);
    chk("udf_flag", 32'(underflow), 1);
    repeat (5) @(posedge rclk);
    #1;
    chk("udf_sticky", 32'(underflow), 1);
    chk("udf_still_empty", 32'(empty), 1);

    // Random handshakes across unrelated clocks, pointers wrapping repeatedly.
    fork
      begin : writer
        int k, cyc;
        k = 0;
        cyc = 0;
        while (k < 200 && cyc < 20000) begin
          @(negedge wclk);
          cyc++;
          if (!full && ($urandom_range(0, 1) == 1)) begin
            wreq  = 1'b1;
            wdata = {10'(2 * k), 10'(2 * k + 1)};
            k++;
          end else begin
            wreq = 1'b0;
          end
        end
        @(negedge wclk);
        wreq = 1'b0;
        chk("cdc_all_written", 32'(k), 200);
      end
      begin : reader
        int s, cyc;
        s = 0;
        cyc = 0;
        while (s < 400 && cyc < 20000) begin
          @(negedge rclk);
          cyc++;
          if (!empty && ($urandom_range(0, 1) == 1)) begin
            rreq = 1'b1;
            @(posedge rclk);
            #1;
            rreq = 1'b0;
            chk("cdc_valid", 32'(rvalid), 1);
            chk("cdc_data", 32'(rdata), 32'(10'(s)));
            s++;
          end else begin
            rreq = 1'b0;
          end
        end
        chk("cdc_all_read", 32'(s), 400);
      end
    join
    chk("cdc_empty_end", 32'(empty), 1);

    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++) wr({10'(100 + i), 10'(200 + i)});
    wait_not_empty("mid_ready");
    rd(d, v);
    chk("mid_d0", 32'(d), 100);
    rd(d, v);
    chk("mid_d1", 32'(d), 200);
    rd(d, v);
    chk("mid_d2", 32'(d), 101);
    @(negedge wclk);
    rst = 1'b0;
    #20;
    chk_reset_state("mid_rst");
    #400;
    rst = 1'b1;
    repeat (4) @(posedge wclk);
    #1;
    chk_reset_state("mid_after");
    wr(20'h00401);
    wait_not_empty("post_rst_ready");
    rd(d, v);
    chk("post_rst_v0", 32'(v), 1);
    chk("post_rst_d0", 32'(d), 1);
    rd(d, v);
    chk("post_rst_v1", 32'(v), 1);
    chk("post_rst_d1", 32'(d), 1);
    chk("post_rst_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
